// File: rtl/zom_sprite_arbiter.sv
// zom_sprite_arbiter: shares one zombie sprite ROM between NUM_ZOM slots.
// Slot position/live state is written into a shadow set and committed to the
// active set on frame_start. A fixed 3-register pipeline (pixel capture, per-slot
// hit test, winner select/address) gives outputs two edges after the pixel is
// sampled. Walk-cycle frames are stepped every ANIM_DIV frame_start pulses.
// Optional feature macro: ZOM_DEPTH_SORT_EN (winner is the hit slot with the
// largest Y, ties to the lower index); undefined selects lowest-index priority.
module zom_sprite_arbiter #(
   parameter int unsigned NUM_ZOM      = 4,
   parameter int unsigned SIZE_X       = 50,
   parameter int unsigned SIZE_Y       = 70,
   parameter int unsigned OFFSET       = 35,
   parameter int unsigned NUM_FRAMES   = 2,
   parameter int unsigned ANIM_DIV     = 8,
   parameter int unsigned DEFAULT_ADDR = 296
) (
   input  logic                        MAX10_CLK1_50,
   input  logic                        Reset,
   input  logic                        frame_start,
   input  logic [9:0]                  DrawX,
   input  logic [9:0]                  DrawY,
   input  logic                        wr_en,
   input  logic [$clog2(NUM_ZOM)-1:0]  wr_idx,
   input  logic [9:0]                  wr_x,
   input  logic [9:0]                  wr_y,
   input  logic                        wr_live,
   output logic [18:0]                 address,
   output logic                        zom_on,
   output logic [$clog2(NUM_ZOM)-1:0]  zom_idx,
   output logic [$clog2(NUM_ZOM):0]    live_cnt
);

   localparam int unsigned IW = $clog2(NUM_ZOM);
   localparam int unsigned LW = IW + 1;
   localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   localparam logic [9:0]    OFF10       = 10'(OFFSET);
   localparam logic [9:0]    SX10        = 10'(SIZE_X);
   localparam logic [9:0]    SY10        = 10'(SIZE_Y);
   localparam logic [18:0]   FRAME_WORDS = 19'(SIZE_X * SIZE_Y);
   localparam logic [18:0]   SX19        = 19'(SIZE_X);
   localparam logic [18:0]   DEF19       = 19'(DEFAULT_ADDR);
   localparam logic [7:0]    DIV_LAST    = 8'(ANIM_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST  = FW'(NUM_FRAMES - 1);

   // slot state: shadow (written any time) and active (used for drawing)
   logic [NUM_ZOM-1:0][9:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
   logic [NUM_ZOM-1:0]      sh_live_q, sh_live_d;
   logic [NUM_ZOM-1:0][9:0] act_x_q, act_x_d, act_y_q, act_y_d;
   logic [NUM_ZOM-1:0]      act_live_q, act_live_d;

   // animation
   logic [7:0]    anim_div_q, anim_div_d;
   logic [FW-1:0] anim_frame_q, anim_frame_d;

   // pipeline
   logic [9:0]              drawx_q, drawy_q;
   logic [NUM_ZOM-1:0]      s1_hit_q, s1_hit_d;
   logic [NUM_ZOM-1:0][9:0] s1_tx_q, s1_tx_d, s1_ty_q, s1_ty_d;
`ifdef ZOM_DEPTH_SORT_EN
   logic [NUM_ZOM-1:0][9:0] s1_y_q, s1_y_d;
   logic [9:0]              best_y;
`endif
   logic                    found;
   logic [IW-1:0]           win;
   logic [9:0]              win_tx, win_ty;

   logic [18:0]   address_q, address_d;
   logic          zom_on_q, zom_on_d;
   logic [IW-1:0] zom_idx_q, zom_idx_d;
   logic [LW-1:0] live_cnt_q, live_cnt_d;

   // shadow write, then commit (including a same-cycle write) on frame_start
   always_comb begin
      sh_x_d     = sh_x_q;
      sh_y_d     = sh_y_q;
      sh_live_d  = sh_live_q;
      if (wr_en) begin
         sh_x_d[wr_idx]    = wr_x;
         sh_y_d[wr_idx]    = wr_y;
         sh_live_d[wr_idx] = wr_live;
      end
      act_x_d    = act_x_q;
      act_y_d    = act_y_q;
      act_live_d = act_live_q;
      if (frame_start) begin
         act_x_d    = sh_x_d;
         act_y_d    = sh_y_d;
         act_live_d = sh_live_d;
      end
      live_cnt_d = LW'($countones(act_live_q));
   end

   // animation divider and frame counter, stepped by frame_start
   always_comb begin
      anim_div_d   = anim_div_q;
      anim_frame_d = anim_frame_q;
      if (frame_start) begin
         if (anim_div_q == DIV_LAST) begin
            anim_div_d   = '0;
            anim_frame_d = (anim_frame_q == FRAME_LAST) ? '0 : anim_frame_q + 1'b1;
         end else begin
            anim_div_d = anim_div_q + 8'd1;
         end
      end
   end

   // S1: per-slot sprite-local coordinates and hit test (10-bit modular, so
   // sprites hanging off the left/top edge clip naturally)
   always_comb begin
      s1_hit_d = '0;
      s1_tx_d  = '0;
      s1_ty_d  = '0;
`ifdef ZOM_DEPTH_SORT_EN
      s1_y_d   = act_y_q;
`endif
      for (int unsigned i = 0; i < NUM_ZOM; i++) begin
         s1_tx_d[i]  = drawx_q - (act_x_q[i] - OFF10);
         s1_ty_d[i]  = drawy_q - (act_y_q[i] - OFF10);
         s1_hit_d[i] = act_live_q[i] && (s1_tx_d[i] < SX10) && (s1_ty_d[i] < SY10);
      end
   end

   // S2: pick the winning slot and form the ROM address
   always_comb begin
      found = 1'b0;
      win   = '0;
`ifdef ZOM_DEPTH_SORT_EN
      best_y = '0;
      for (int unsigned i = 0; i < NUM_ZOM; i++) begin
         if (s1_hit_q[i] && (!found || (s1_y_q[i] > best_y))) begin
            found  = 1'b1;
            win    = IW'(i);
            best_y = s1_y_q[i];
         end
      end
`else
      for (int unsigned i = 0; i < NUM_ZOM; i++) begin
         if (s1_hit_q[i] && !found) begin
            found = 1'b1;
            win   = IW'(i);
         end
      end
`endif
      win_tx    = s1_tx_q[win];
      win_ty    = s1_ty_q[win];
      zom_on_d  = found;
      zom_idx_d = win;
      address_d = found ? (19'(anim_frame_q) * FRAME_WORDS + 19'(win_ty) * SX19 + 19'(win_tx))
                        : DEF19;
   end

   // state registers with synchronous reset
   always_ff @(posedge MAX10_CLK1_50) begin
      if (Reset) begin
         sh_x_q       <= '0;
         sh_y_q       <= '0;
         sh_live_q    <= '0;
         act_x_q      <= '0;
         act_y_q      <= '0;
         act_live_q   <= '0;
         anim_div_q   <= '0;
         anim_frame_q <= '0;
         drawx_q      <= '0;
         drawy_q      <= '0;
         s1_hit_q     <= '0;
         s1_tx_q      <= '0;
         s1_ty_q      <= '0;
`ifdef ZOM_DEPTH_SORT_EN
         s1_y_q       <= '0;
`endif
         address_q    <= DEF19;
         zom_on_q     <= 1'b0;
         zom_idx_q    <= '0;
         live_cnt_q   <= '0;
      end else begin
         sh_x_q       <= sh_x_d;
         sh_y_q       <= sh_y_d;
         sh_live_q    <= sh_live_d;
         act_x_q      <= act_x_d;
         act_y_q      <= act_y_d;
         act_live_q   <= act_live_d;
         anim_div_q   <= anim_div_d;
         anim_frame_q <= anim_frame_d;
         drawx_q      <= DrawX;
         drawy_q      <= DrawY;
         s1_hit_q     <= s1_hit_d;
         s1_tx_q      <= s1_tx_d;
         s1_ty_q      <= s1_ty_d;
`ifdef ZOM_DEPTH_SORT_EN
         s1_y_q       <= s1_y_d;
`endif
         address_q    <= address_d;
         zom_on_q     <= zom_on_d;
         zom_idx_q    <= zom_idx_d;
         live_cnt_q   <= live_cnt_d;
      end
   end

   assign address  = address_q;
   assign zom_on   = zom_on_q;
   assign zom_idx  = zom_idx_q;
   assign live_cnt = live_cnt_q;

endmodule

// File: tb/tb_zom_sprite_arbiter.sv
// Testbench for zom_sprite_arbiter: directed cases plus randomized traffic.
// A reference model (per-edge snapshots of slot state, frame_start count)
// pushes the expected output of every edge into a queue; a monitor pops and
// compares each cycle. Directed spot checks use fixed constants.
module tb_zom_sprite_arbiter;

   localparam int NZ  = 4;
   localparam int SX  = 50;
   localparam int SY  = 70;
   localparam int OFF = 35;
   localparam int NF  = 2;
   localparam int AD  = 8;
   localparam int DEF = 296;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_idx = '0;
   logic [9:0]  wr_x = '0, wr_y = '0;
   logic        wr_live = 1'b0;
   logic [18:0] address;
   logic        zom_on;
   logic [1:0]  zom_idx;
   logic [2:0]  live_cnt;

   always #5 clk = ~clk;

   zom_sprite_arbiter #(
      .NUM_ZOM(NZ), .SIZE_X(SX), .SIZE_Y(SY), .OFFSET(OFF),
      .NUM_FRAMES(NF), .ANIM_DIV(AD), .DEFAULT_ADDR(DEF)
   ) dut (
      .MAX10_CLK1_50(clk), .Reset(Reset), .frame_start(frame_start),
      .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_x(wr_x), .wr_y(wr_y), .wr_live(wr_live),
      .address(address), .zom_on(zom_on), .zom_idx(zom_idx), .live_cnt(live_cnt)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   typedef struct packed {
      logic        on;
      logic [1:0]  idx;
      logic [18:0] addr;
      logic [2:0]  live;
   } exp_t;

   // state after one clock edge, plus the pixel sampled at that edge
   typedef struct packed {
      logic           rst;
      logic [NZ-1:0][9:0] x;
      logic [NZ-1:0][9:0] y;
      logic [NZ-1:0]  l;
      logic [9:0]     px;
      logic [9:0]     py;
      int             anim;
   } snap_t;

   exp_t sb_q[$];

   // reference model state
   logic [NZ-1:0][9:0] m_sx = '0, m_sy = '0, m_ax = '0, m_ay = '0;
   logic [NZ-1:0]      m_sl = '0, m_al = '0;
   int                 fs_count = 0;
   snap_t              h1 = '{rst: 1'b1, default: '0};
   snap_t              h2 = '{rst: 1'b1, default: '0};

   function automatic exp_t evaluate(snap_t p, int anim);
      exp_t e;
      int   best_y;
      e = '{on: 1'b0, idx: 2'd0, addr: 19'(DEF), live: 3'd0};
      best_y = -1;
      for (int i = 0; i < NZ; i++) begin
         int tx, ty;
         tx = ((int'(p.px) - (int'(p.x[i]) - OFF)) % 1024 + 1024) % 1024;
         ty = ((int'(p.py) - (int'(p.y[i]) - OFF)) % 1024 + 1024) % 1024;
         if (p.l[i] && tx < SX && ty < SY) begin
`ifdef ZOM_DEPTH_SORT_EN
            if (!e.on || int'(p.y[i]) > best_y) begin
`else
            if (!e.on) begin
`endif
               e.on   = 1'b1;
               e.idx  = 2'(i);
               e.addr = 19'(anim * SX * SY + ty * SX + tx);
               best_y = int'(p.y[i]);
            end
         end
      end
      return e;
   endfunction

   // model: update slot state for this edge, push expected output of this edge
   always @(posedge clk) begin : model
      snap_t cur;
      exp_t  e;
      if (Reset) begin
         m_sx = '0; m_sy = '0; m_sl = '0;
         m_ax = '0; m_ay = '0; m_al = '0;
         fs_count = 0;
      end else begin
         if (wr_en) begin
            m_sx[wr_idx] = wr_x;
            m_sy[wr_idx] = wr_y;
            m_sl[wr_idx] = wr_live;
         end
         if (frame_start) begin
            m_ax = m_sx; m_ay = m_sy; m_al = m_sl;
            fs_count++;
         end
      end
      cur.rst  = Reset;
      cur.x    = m_ax;
      cur.y    = m_ay;
      cur.l    = m_al;
      cur.px   = Reset ? 10'd0 : DrawX;
      cur.py   = Reset ? 10'd0 : DrawY;
      cur.anim = (fs_count / AD) % NF;
      if (Reset || h1.rst)
         e = '{on: 1'b0, idx: 2'd0, addr: 19'(DEF), live: 3'd0};
      else
         e = evaluate(h2, h1.anim);
      e.live = Reset ? 3'd0 : 3'($countones(h1.l));
      sb_q.push_back(e);
      h2 = h1;
      h1 = cur;
   end

   // monitor: compare every cycle's outputs against the queued expectation
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         checks++;
         if (zom_on !== e.on || zom_idx !== e.idx || address !== e.addr || live_cnt !== e.live) begin
            errors++;
            $display("FAIL sb t=%0t: got on=%0d idx=%0d addr=%0d live=%0d expected on=%0d idx=%0d addr=%0d live=%0d",
                     $time, zom_on, zom_idx, address, live_cnt, e.on, e.idx, e.addr, e.live);
         end
      end
   end

   // present a pixel and check outputs two edges after it is sampled
   task automatic spot(string nm, int x, int y, int e_on, int e_idx, int e_addr);
      DrawX = 10'(x);
      DrawY = 10'(y);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_on"}, int'(zom_on), e_on);
      chk({nm, "_idx"}, int'(zom_idx), e_idx);
      chk({nm, "_addr"}, int'(address), e_addr);
      @(negedge clk);
   endtask

   task automatic write_slot(int idx, int x, int y, bit live, bit fs);
      wr_en = 1'b1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_live = live;
      frame_start = fs;
      @(negedge clk);
      wr_en = 1'b0; frame_start = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
   endtask

`ifdef ZOM_DEPTH_SORT_EN
   localparam int OVL_IDX = 2, OVL_ADDR = 15 * 50 + 15;
`else
   localparam int OVL_IDX = 0, OVL_ADDR = 35 * 50 + 25;
`endif

   initial begin
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         DrawX = 10'($urandom_range(0, 639));
         DrawY = 10'($urandom_range(0, 479));
         @(negedge clk);
      end
      chk("live_after_reset", int'(live_cnt), 0);

      write_slot(0, 100, 100, 1'b1, 1'b1);
      spot("s0_corner", 65, 65, 1, 0, 0);
      spot("s0_bottom_right", 114, 134, 1, 0, 3499);
      spot("s0_right_edge", 115, 134, 0, 0, DEF);
      chk("live_one", int'(live_cnt), 1);

      write_slot(1, 200, 100, 1'b1, 1'b0);
      spot("s1_uncommitted", 165, 65, 0, 0, DEF);
      chk("live_still_one", int'(live_cnt), 1);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("live_commit_edge", int'(live_cnt), 1);
      @(negedge clk);
      chk("live_after_commit", int'(live_cnt), 2);
      spot("s1_committed", 165, 65, 1, 1, 0);

      write_slot(2, 110, 120, 1'b1, 1'b1);
      spot("overlap", 90, 100, 1, OVL_IDX, OVL_ADDR);

      write_slot(0, 20, 30, 1'b1, 1'b1);
      spot("clip_top_left", 0, 0, 1, 0, 265);
      spot("clip_right", 34, 0, 1, 0, 299);

      // randomized traffic, checked by the scoreboard
      for (int i = 0; i < 1500; i++) begin
         Reset       = ($urandom_range(0, 299) == 0);
         frame_start = ($urandom_range(0, 11) == 0);
         wr_en       = ($urandom_range(0, 2) == 0);
         wr_idx      = 2'($urandom_range(0, NZ - 1));
         wr_x        = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                   : 10'($urandom_range(0, 300));
         wr_y        = 10'($urandom_range(0, 300));
         wr_live     = ($urandom_range(0, 3) != 0);
         DrawX       = 10'($urandom_range(0, 340));
         DrawY       = 10'($urandom_range(0, 340));
         @(negedge clk);
      end
      Reset = 1'b0; frame_start = 1'b0; wr_en = 1'b0;

      // animation stepping from a clean reset
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      write_slot(0, 100, 100, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) pulse_fs();
      spot("anim_step", 65, 65, 1, 0, 3500);
      for (int i = 0; i < 8; i++) pulse_fs();
      spot("anim_wrap", 65, 65, 1, 0, 0);

      // reset while a zombie is being drawn
      Reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_zom_on", int'(zom_on), 0);
      chk("reset_addr", int'(address), DEF);
      @(negedge clk);
      Reset = 1'b0;
      spot("post_reset", 65, 65, 0, 0, DEF);
      chk("post_reset_live", int'(live_cnt), 0);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
